sign_run_tracker: RTL

//  Downstream consumer of the per-sample sign classifier (positive_flag / negative_flag pair).

---
 rtl/sign_pkg.sv | 12 +
 rtl/sat_counter.sv | 39 +++
 rtl/sign_run_tracker.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sign_pkg.sv
// Shared sign-class encodings for the sign classifier, its checkers and
// the run tracker. Class is {negative_flag, positive_flag}.
package sign_pkg;

  localparam logic [1:0] CLS_ZERO    = 2'b00;
  localparam logic [1:0] CLS_POS     = 2'b01;
  localparam logic [1:0] CLS_NEG     = 2'b10;
  localparam logic [1:0] CLS_ILLEGAL = 2'b11;

  localparam int CAND_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous load and clear.
// Ports: clk, rst_n, inc, load, load_val, clr -> cnt (load > clr > inc).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sign_run_tracker.sv
// Debounces the classifier sign pair, tracks run length, flags both-high.
// Ports: clk, rst_n, valid_in, pos/neg_flag_in, err_clr -> sign_state,
//        sign_change, run_len, mutex_err, err_cnt (all registered).
module sign_run_tracker
  import sign_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8,
  parameter int ERR_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             pos_flag_in,
  input  logic             neg_flag_in,
  input  logic             err_clr,
  output logic [1:0]       sign_state,
  output logic             sign_change,
  output logic [CNT_W-1:0] run_len,
  output logic             mutex_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RUN_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] RUN_LOAD =
    CNT_W'((DEBOUNCE > RUN_MAX) ? RUN_MAX : DEBOUNCE);
  localparam logic [CAND_W-1:0] DEB = CAND_W'(DEBOUNCE);

  logic [1:0]        cls;
  logic              illegal;
  logic              same;
  logic              diff;
  logic              cand_hit;
  logic              commit;
  logic [CAND_W-1:0] cand_cnt;
  logic [CAND_W-1:0] cand_next;

  logic [1:0] sign_state_q, sign_state_d;
  logic       sign_change_q, sign_change_d;
  logic       mutex_err_q, mutex_err_d;
  logic [1:0] cand_q, cand_d;

  assign cls      = {neg_flag_in, pos_flag_in};
  assign illegal  = valid_in && (cls == CLS_ILLEGAL);
  assign same     = valid_in && !illegal && (cls == sign_state_q);
  assign diff     = valid_in && !illegal && !same;
  assign cand_hit = (cls == cand_q);

  // Progress the candidate would reach with this sample.
  assign cand_next = cand_hit ? cand_cnt + 1'b1 : CAND_W'(1);
  assign commit    = diff && (cand_next == DEB);

  always_comb begin
    sign_state_d  = sign_state_q;
    sign_change_d = 1'b0;
    cand_d        = cand_q;
    mutex_err_d   = mutex_err_q;
    if (diff) begin
      cand_d = cls;
    end
    if (commit) begin
      sign_state_d  = cls;
      sign_change_d = 1'b1;
    end
    // Setting the sticky flag beats a same-cycle clear.
    if (illegal) begin
      mutex_err_d = 1'b1;
    end else if (err_clr) begin
      mutex_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_state_q  <= CLS_ZERO;
      sign_change_q <= 1'b0;
      mutex_err_q   <= 1'b0;
      cand_q        <= CLS_ZERO;
    end else begin
      sign_state_q  <= sign_state_d;
      sign_change_q <= sign_change_d;
      mutex_err_q   <= mutex_err_d;
      cand_q        <= cand_d;
    end
  end

  sat_counter #(.W(CAND_W)) u_cand_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (diff && cand_hit && !commit),
    .load     (diff && !cand_hit && !commit),
    .load_val (CAND_W'(1)),
    .clr      (illegal || same || commit),
    .cnt      (cand_cnt)
  );

  sat_counter #(.W(CNT_W)) u_run_len (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (same),
    .load     (commit),
    .load_val (RUN_LOAD),
    .clr      (1'b0),
    .cnt      (run_len)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (illegal),
    .load     (illegal && err_clr),
    .load_val (ERR_W'(1)),
    .clr      (err_clr),
    .cnt      (err_cnt)
  );

  assign sign_state  = sign_state_q;
  assign sign_change = sign_change_q;
  assign mutex_err   = mutex_err_q;

endmodule
